// File: rtl/sprite_mem_arbiter.sv
// sprite_mem_arbiter: shares the single-port sprite RAM between pixel fetch
// (strict priority), the animation updater and the CPU load port (round-robin
// between themselves, with a starvation escape that pre-empts pixel fetch).
// Accepted requests are registered onto the memory command port; read data is
// routed back through a tag pipeline that raises the owner's rvalid.
module sprite_mem_arbiter #(
   parameter int AW       = 17,
   parameter int DW       = 8,
   parameter int RD_LAT   = 2,
   parameter int MAX_WAIT = 15
) (
   input  logic          Clk,
   input  logic          Reset_n,
   input  logic          px_req,
   input  logic [AW-1:0] px_addr,
   output logic          px_gnt,
   input  logic          an_req,
   input  logic [AW-1:0] an_addr,
   output logic          an_gnt,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic [DW-1:0] rd_data,
   output logic          px_rvalid,
   output logic          an_rvalid,
   output logic          cpu_rvalid,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic { RR_AN = 1'b0, RR_CPU = 1'b1 } rr_e;

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_PX   = 2'd1,
      TAG_AN   = 2'd2,
      TAG_CPU  = 2'd3
   } tag_e;

   // Tag pipeline holds 1+RD_LAT two-bit ids; the newest id sits in the LSBs.
   localparam int         TW       = 2 * (RD_LAT + 1);
   localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

   rr_e           rr_q, rr_d;
   logic [7:0]    an_wait_q, an_wait_d;
   logic [7:0]    cpu_wait_q, cpu_wait_d;
   logic          mem_en_q, mem_en_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [TW-1:0] tag_q, tag_d;
   logic [1:0]    new_tag;
   logic          an_starved, cpu_starved;

   // Grant selection: starved low-priority port, then pixel fetch, then round-robin.
   always_comb begin
      px_gnt      = 1'b0;
      an_gnt      = 1'b0;
      cpu_gnt     = 1'b0;
      an_starved  = an_req  && (an_wait_q  == WAIT_MAX);
      cpu_starved = cpu_req && (cpu_wait_q == WAIT_MAX);
      if (!Reset_n) begin
         px_gnt = 1'b0;
      end else if (an_starved && cpu_starved) begin
         if (rr_q == RR_AN) an_gnt = 1'b1;
         else               cpu_gnt = 1'b1;
      end else if (an_starved) begin
         an_gnt = 1'b1;
      end else if (cpu_starved) begin
         cpu_gnt = 1'b1;
      end else if (px_req) begin
         px_gnt = 1'b1;
      end else if (an_req && cpu_req) begin
         if (rr_q == RR_AN) an_gnt = 1'b1;
         else               cpu_gnt = 1'b1;
      end else if (an_req) begin
         an_gnt = 1'b1;
      end else if (cpu_req) begin
         cpu_gnt = 1'b1;
      end
   end

   // Next-state: round-robin pointer, wait counters, command register, tag shift.
   always_comb begin
      rr_d = rr_q;
      if (an_gnt)       rr_d = RR_CPU;
      else if (cpu_gnt) rr_d = RR_AN;

      an_wait_d = '0;
      if (an_req && !an_gnt)
         an_wait_d = (an_wait_q == WAIT_MAX) ? WAIT_MAX : an_wait_q + 8'd1;

      cpu_wait_d = '0;
      if (cpu_req && !cpu_gnt)
         cpu_wait_d = (cpu_wait_q == WAIT_MAX) ? WAIT_MAX : cpu_wait_q + 8'd1;

      mem_en_d    = px_gnt | an_gnt | cpu_gnt;
      mem_we_d    = cpu_gnt & cpu_we;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      new_tag     = TAG_NONE;
      if (px_gnt) begin
         mem_addr_d = px_addr;
         new_tag    = TAG_PX;
      end else if (an_gnt) begin
         mem_addr_d = an_addr;
         new_tag    = TAG_AN;
      end else if (cpu_gnt) begin
         mem_addr_d  = cpu_addr;
         mem_wdata_d = cpu_wdata;
         new_tag     = cpu_we ? TAG_NONE : TAG_CPU;
      end

      tag_d = {tag_q[TW-3:0], new_tag};
   end

   // State registers; reset also flushes in-flight read tags.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rr_q        <= RR_AN;
         an_wait_q   <= '0;
         cpu_wait_q  <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         tag_q       <= '0;
      end else begin
         rr_q        <= rr_d;
         an_wait_q   <= an_wait_d;
         cpu_wait_q  <= cpu_wait_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         tag_q       <= tag_d;
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

   assign rd_data    = mem_rdata;
   assign px_rvalid  = (tag_q[TW-1 -: 2] == TAG_PX);
   assign an_rvalid  = (tag_q[TW-1 -: 2] == TAG_AN);
   assign cpu_rvalid = (tag_q[TW-1 -: 2] == TAG_CPU);

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// Testbench for sprite_mem_arbiter: directed scenarios followed by randomized
// traffic, with expected commands and read returns queued by a reference model
// and popped by an independent monitor.
module tb_sprite_mem_arbiter;

   localparam int AW       = 17;
   localparam int DW       = 8;
   localparam int RD_LAT   = 2;
   localparam int MAX_WAIT = 15;

   logic          Clk = 1'b0;
   logic          Reset_n = 1'b0;
   logic          px_req, an_req, cpu_req, cpu_we;
   logic [AW-1:0] px_addr, an_addr, cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          px_gnt, an_gnt, cpu_gnt;
   logic [DW-1:0] rd_data;
   logic          px_rvalid, an_rvalid, cpu_rvalid;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   sprite_mem_arbiter #(
      .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .px_req(px_req), .px_addr(px_addr), .px_gnt(px_gnt),
      .an_req(an_req), .an_addr(an_addr), .an_gnt(an_gnt),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
      .rd_data(rd_data),
      .px_rvalid(px_rvalid), .an_rvalid(an_rvalid), .cpu_rvalid(cpu_rvalid),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 Clk = ~Clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   always @(posedge Clk) cyc++;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Default RAM contents, shared by the memory environment and the model.
   function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction

   // Sprite RAM environment: RD_LAT-cycle read pipeline behind the command port.
   logic [DW-1:0] sram [logic [AW-1:0]];
   logic [DW-1:0] rpipe [RD_LAT];

   always @(posedge Clk) begin
      for (int i = RD_LAT - 1; i > 0; i--) rpipe[i] = rpipe[i-1];
      rpipe[0] = 8'hEE;
      if (mem_en) begin
         if (mem_we) sram[mem_addr] = mem_wdata;
         else rpipe[0] = sram.exists(mem_addr) ? sram[mem_addr] : init_val(mem_addr);
      end
   end

   assign mem_rdata = rpipe[RD_LAT-1];

   // Reference model state and scoreboard queues.
   typedef struct { int due; logic [AW-1:0] addr; logic we; logic [DW-1:0] wdata; } cmd_t;
   typedef struct { int due; int id; logic [DW-1:0] data; } rd_t;

   cmd_t cmdq [$];
   rd_t  rdq [$];
   logic [DW-1:0] ref_mem [logic [AW-1:0]];
   int rr_next;   // 2 = animation goes next on a tie, 3 = CPU
   int an_wait, cpu_wait;

   int            s_gnt, s_rv;
   logic [DW-1:0] s_rdata, s_mem_wdata;
   logic          s_mem_en, s_mem_we;
   logic [AW-1:0] s_mem_addr;

   int pxp [4] = '{100, 50, 30, 0};
   int lop [4] = '{40, 70, 50, 100};
   int wdp [4] = '{5, 5, 20, 0};

   function automatic logic [DW-1:0] ref_read(logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   function automatic logic [AW-1:0] rnd_addr();
      logic [3:0] lo;
      lo = 4'($urandom_range(0, 15));
      return ($urandom_range(0, 1) == 0) ? {{(AW-4){1'b0}}, lo} : {{(AW-4){1'b1}}, lo};
   endfunction

   function automatic int gnt_code();
      case ({px_gnt, an_gnt, cpu_gnt})
         3'b000:  return 0;
         3'b100:  return 1;
         3'b010:  return 2;
         3'b001:  return 3;
         default: return 7;
      endcase
   endfunction

   function automatic int rv_code();
      case ({px_rvalid, an_rvalid, cpu_rvalid})
         3'b000:  return 0;
         3'b100:  return 1;
         3'b010:  return 2;
         3'b001:  return 3;
         default: return 7;
      endcase
   endfunction

   // Who should win this cycle, straight from the priority rules.
   function automatic int model_grant();
      bit an_st, cpu_st;
      an_st  = an_req  && (an_wait  >= MAX_WAIT);
      cpu_st = cpu_req && (cpu_wait >= MAX_WAIT);
      if (an_st && cpu_st) return rr_next;
      if (an_st) return 2;
      if (cpu_st) return 3;
      if (px_req) return 1;
      if (an_req && cpu_req) return rr_next;
      if (an_req) return 2;
      if (cpu_req) return 3;
      return 0;
   endfunction

   task automatic model_commit(int g);
      cmd_t c;
      rd_t r;
      logic [AW-1:0] a;
      if (g != 0) begin
         a = (g == 1) ? px_addr : (g == 2) ? an_addr : cpu_addr;
         c.due = cyc + 1;
         c.addr = a;
         c.we = (g == 3) && cpu_we;
         c.wdata = cpu_wdata;
         cmdq.push_back(c);
         if (c.we) begin
            ref_mem[a] = cpu_wdata;
         end else begin
            r.due = cyc + 1 + RD_LAT;
            r.id = g;
            r.data = ref_read(a);
            rdq.push_back(r);
         end
      end
      if (g == 2) rr_next = 3;
      else if (g == 3) rr_next = 2;
      an_wait  = (an_req  && g != 2) ? ((an_wait  < MAX_WAIT) ? an_wait + 1  : MAX_WAIT) : 0;
      cpu_wait = (cpu_req && g != 3) ? ((cpu_wait < MAX_WAIT) ? cpu_wait + 1 : MAX_WAIT) : 0;
   endtask

   task automatic reset_model();
      rr_next = 2;
      an_wait = 0;
      cpu_wait = 0;
      cmdq.delete();
      rdq.delete();
   endtask

   // One clock: sample mid-cycle, check the grant, queue expectations, advance.
   task automatic step();
      int exp_g, act_g;
      @(negedge Clk);
      act_g = gnt_code();
      exp_g = model_grant();
      check($sformatf("grant@%0d", cyc), act_g, exp_g);
      s_gnt = act_g;
      s_rv = rv_code();
      s_rdata = rd_data;
      s_mem_en = mem_en;
      s_mem_we = mem_we;
      s_mem_addr = mem_addr;
      s_mem_wdata = mem_wdata;
      model_commit(exp_g);
      @(posedge Clk);
      #1;
   endtask

   task automatic idle(int n);
      px_req = 1'b0;
      an_req = 1'b0;
      cpu_req = 1'b0;
      cpu_we = 1'b0;
      repeat (n) step();
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_gnt"}, {px_gnt, an_gnt, cpu_gnt}, 0);
      check({tag, "_mem_ctl"}, {mem_en, mem_we}, 0);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_mem_wdata"}, mem_wdata, 0);
      check({tag, "_rvalid"}, {px_rvalid, an_rvalid, cpu_rvalid}, 0);
   endtask

   // Requesters keep req/address stable until granted; low-priority ports may withdraw.
   task automatic drive_random(int px_pct, int lo_pct, int wd_pct);
      if (s_gnt == 1 || !px_req) begin
         px_req = (int'($urandom_range(0, 99)) < px_pct);
         px_addr = rnd_addr();
      end
      if (s_gnt == 2 || !an_req) begin
         an_req = (int'($urandom_range(0, 99)) < lo_pct);
         an_addr = rnd_addr();
      end else if (int'($urandom_range(0, 99)) < wd_pct) begin
         an_req = 1'b0;
      end
      if (s_gnt == 3 || !cpu_req) begin
         cpu_req = (int'($urandom_range(0, 99)) < lo_pct);
         cpu_addr = rnd_addr();
         cpu_we = ($urandom_range(0, 2) == 0);
         cpu_wdata = DW'($urandom);
      end else if (int'($urandom_range(0, 99)) < wd_pct) begin
         cpu_req = 1'b0;
      end
   endtask

   // Monitor: pops expected commands and read returns as the DUT presents them.
   cmd_t mc;
   rd_t  mr;
   int   mn, mid;

   always @(negedge Clk) begin
      if (Reset_n) begin
         if (mem_en) begin
            if (cmdq.size() == 0) begin
               check($sformatf("cmd_unexpected@%0d", cyc), mem_en, 0);
            end else begin
               mc = cmdq.pop_front();
               check($sformatf("cmd_time@%0d", cyc), cyc, mc.due);
               check($sformatf("cmd_addr@%0d", cyc), mem_addr, mc.addr);
               check($sformatf("cmd_we@%0d", cyc), mem_we, mc.we);
               if (mc.we) check($sformatf("cmd_wdata@%0d", cyc), mem_wdata, mc.wdata);
            end
         end else if (cmdq.size() != 0 && cmdq[0].due <= cyc) begin
            mc = cmdq.pop_front();
            check($sformatf("cmd_missing@%0d", cyc), 0, 1);
         end

         mn = int'(px_rvalid) + int'(an_rvalid) + int'(cpu_rvalid);
         if (mn > 1) begin
            check($sformatf("rvalid_onehot@%0d", cyc), mn, 1);
         end else if (mn == 1) begin
            mid = px_rvalid ? 1 : an_rvalid ? 2 : 3;
            if (rdq.size() == 0) begin
               check($sformatf("rvalid_unexpected@%0d", cyc), mid, 0);
            end else begin
               mr = rdq.pop_front();
               check($sformatf("rd_id@%0d", cyc), mid, mr.id);
               check($sformatf("rd_time@%0d", cyc), cyc, mr.due);
               check($sformatf("rd_data@%0d", cyc), rd_data, mr.data);
            end
         end else if (rdq.size() != 0 && rdq[0].due <= cyc) begin
            mr = rdq.pop_front();
            check($sformatf("rd_missing@%0d", cyc), 0, mr.id);
         end
      end
   end

   initial begin
      int lat, resumed, nrv;
      logic [DW-1:0] rdv;

      px_req = 1'b0; an_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
      px_addr = '0; an_addr = '0; cpu_addr = '0; cpu_wdata = '0;
      reset_model();

      // Reset values, with requests pending to show grants are held off.
      repeat (3) @(posedge Clk);
      #1;
      px_req = 1'b1; an_req = 1'b1; cpu_req = 1'b1;
      #1;
      check_reset_outputs("reset");
      px_req = 1'b0; an_req = 1'b0; cpu_req = 1'b0;
      Reset_n = 1'b1;

      // Single pixel read: command one cycle later, data RD_LAT after that.
      px_req = 1'b1;
      px_addr = 17'h00010;
      step();
      check("t1_px_gnt", s_gnt, 1);
      px_req = 1'b0;
      lat = -1;
      for (int k = 0; k < 8; k++) begin
         step();
         if (k == 0) check("t1_mem_cmd", {s_mem_en, s_mem_we, s_mem_addr}, {1'b1, 1'b0, 17'h00010});
         if (s_rv == 1 && lat < 0) begin
            lat = k;
            rdv = s_rdata;
         end
      end
      check("t1_rvalid_lat", lat, RD_LAT);
      check("t1_rd_data", rdv, init_val(17'h00010));

      // Animation and CPU both holding: strict alternation starting with animation.
      an_req = 1'b1; an_addr = 17'h00100;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00200;
      for (int i = 0; i < 6; i++) begin
         step();
         check($sformatf("t2_rr%0d", i), s_gnt, (i % 2 == 0) ? 2 : 3);
      end
      idle(RD_LAT + 3);

      // Continuous pixel traffic: animation escapes after MAX_WAIT blocked cycles.
      px_req = 1'b1; px_addr = rnd_addr();
      an_req = 1'b1; an_addr = 17'h00ABC;
      lat = -1;
      resumed = 0;
      for (int t = 0; t < MAX_WAIT + 4; t++) begin
         step();
         if (lat >= 0 && t == lat + 1) resumed = (s_gnt == 1) ? 1 : 0;
         if (s_gnt == 2 && lat < 0) begin
            lat = t;
            an_req = 1'b0;
         end
         if (s_gnt == 1) px_addr = rnd_addr();
      end
      check("t3_an_wait", lat, MAX_WAIT);
      check("t3_px_resume", resumed, 1);
      idle(RD_LAT + 3);

      // CPU write to the top address, then read it back.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h1FFFF; cpu_wdata = 8'hA5;
      step();
      check("t4_wr_gnt", s_gnt, 3);
      cpu_we = 1'b0; cpu_wdata = 8'h00;
      step();
      check("t4_wr_cmd", {s_mem_en, s_mem_we, s_mem_addr, s_mem_wdata}, {1'b1, 1'b1, 17'h1FFFF, 8'hA5});
      cpu_req = 1'b0;
      rdv = '0;
      lat = -1;
      for (int k = 0; k < 8; k++) begin
         step();
         if (s_rv == 3 && lat < 0) begin
            lat = k;
            rdv = s_rdata;
         end
      end
      check("t4_rd_seen", (lat >= 0) ? 1 : 0, 1);
      check("t4_rd_data", rdv, 8'hA5);
      idle(2);

      // Three reads in flight, then a reset pulse drops them all.
      px_req = 1'b1; px_addr = 17'h00033;
      an_req = 1'b1; an_addr = 17'h00044;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00055;
      for (int i = 0; i < 3; i++) begin
         step();
         if (s_gnt == 1) px_req = 1'b0;
         if (s_gnt == 2) an_req = 1'b0;
         if (s_gnt == 3) cpu_req = 1'b0;
      end
      check("t5_all_accepted", {px_req, an_req, cpu_req}, 0);
      Reset_n = 1'b0;
      reset_model();
      #1;
      check_reset_outputs("t5_reset");
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      nrv = 0;
      for (int k = 0; k < RD_LAT + 6; k++) begin
         step();
         if (s_rv != 0) nrv++;
      end
      check("t5_no_rvalid", nrv, 0);

      // Randomized traffic at several load mixes.
      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < 400; i++) begin
            step();
            drive_random(pxp[p], lop[p], wdp[p]);
         end
      end

      idle(RD_LAT + 6);
      check("drain_cmdq", cmdq.size(), 0);
      check("drain_rdq", rdq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
